yuv422_rgb_pipe: RTL and testbench
==================================

// Module: yuv422_rgb_pipe
// PURPOSE
//  Pipelined, parametrised YUV422->RGB converter for the camera path; successor of the single-pixel converter.
//  Accepts one 32-bit word (two pixels), emits one RGB pixel/cycle with a finger-colour flag.
//  Valid/ready on both sides. Sits between camera capture FIFO and the finger-detection/display logic.
// PARAMETERS
//  CH_BITS      3    output bits per colour channel (1..8); out_rgb = 3*CH_BITS
//  LINE_PIXELS  640  pixels per line; sizes x counter and stats fields
//  XW           $clog2(LINE_PIXELS)  derived localparam, x/stat width
// PORTS
//  clk          in   1          sole clock, rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  in_valid     in   1          in_data/in_sol valid
//  in_ready     out  1          word accepted when in_valid&&in_ready
//  in_data      in   32         [31:24]=V [23:16]=Y1 [15:8]=U [7:0]=Y0
//  in_sol       in   1          word starts a new line
//  out_valid    out  1          pixel valid
//  out_ready    in   1          downstream accepts pixel
//  out_rgb      out  3*CH_BITS  {R,G,B}, each = top CH_BITS of clamped 8-bit channel
//  out_finger   out  1          r<thr_r_max && g>thr_g_min && b<thr_b_max (8-bit clamped values)
//  out_eol      out  1          pixel is x==LINE_PIXELS-1
//  thr_r_max    in   8          finger thresholds, quasi-static
//  thr_g_min    in   8
//  thr_b_max    in   8
//  stat_valid   out  1          1-cycle pulse per line (FINGER_STATS_EN)
//  stat_count   out  XW+1       finger pixels in line
//  stat_first   out  XW         x of first finger pixel (0 if none)
//  stat_last    out  XW         x of last finger pixel (0 if none)
// BEHAVIOUR
//  Reset: all valids 0, in_ready 0 during reset, out_* / stat_* 0, serializer EMPTY, x=0.
//  Serializer FSM: EMPTY -(accept)-> PIX1 (Y1 with U,V) -(advance)-> PIX0 (Y0, same U,V) -(advance)-> EMPTY,
//   or PIX0 -(advance & accept)-> PIX1 directly. in_ready = !stall && state!=PIX1.
//  Pipeline: SER -> S1 (products) -> S2 (sums, clamp, compare) -> OUT register.
//  Stall = out_valid && !out_ready; on stall every stage holds, nothing lost or duplicated.
//  Latency: Y1 pixel out_valid 3 cycles after input handshake; Y0 pixel next cycle; sustained 1 px/clk.
//  Arithmetic, signed 32-bit: Y'=Y-16, U'=U-128, V'=V-128; C=298*Y'
//   R=C+409V'+128; G=C-100U'-208V'+128; B=C+516U'+128.
//  Clamp: negative->0; >=65536->255; else bits [15:8]. Threshold compares are strict, unsigned 8-bit.
//  x counter: increments on output handshake; pixel carrying in_sol (the Y1 pixel) forces x=0;
//   out_eol at x==LINE_PIXELS-1; x wraps to 0 after eol even without sol.
//  Thresholds are sampled at S2 with each pixel; changing them mid-line affects subsequent pixels only.
//  in_sol mid-line: x restarts at 0, current stats discarded (no stat_valid).
//  Reset mid-operation: in-flight pixels dropped, no partial stat_valid.
// CONFIGURATION
//  FINGER_STATS_EN defined: per-line count/first/last accumulated on out handshakes of finger pixels;
//   on eol handshake stat_* update and stat_valid pulses 1 cycle (stats of the line just ended).
//  Undefined: stats logic absent, stat_valid/stat_count/stat_first/stat_last tied 0.
// STRUCTURE
//  Package yuv_rgb_pkg: coefficient constants (298,409,100,208,516), offsets (16,128,rounding 128),
//   clamp8 function, threshold compare function.
//  Sub-module yuv_rgb_core: one-pixel S1/S2 arithmetic+clamp+finger compare with enable; top holds FSM,
//   valid/stall, x counter, stats.
// TESTING
//  Black: in_data={8'd128,8'd16,8'd128,8'd16}, CH_BITS=3 -> two pixels out_rgb=9'h000, at cycles +3,+4.
//  White/red: {V=128,Y1=235,U=128,Y0=81}... use word {240,235,90,81}? no: test white word {128,235,128,235} -> 9'h1FF x2;
//   red Y=81,U=90,V=240 both pixels -> R=255,G=0,B=0, out_rgb=9'h1C0.
//  Back-pressure: stream 8 words, out_ready random 50% -> 16 pixels, order Y1,Y0 per word, none lost/duped.
//  Finger: thr=(200,50,200), pixels rgb8=(100,100,100) at x=5..9, rest white; eol -> stat_count=5,
//   stat_first=5, stat_last=9, stat_valid 1 cycle (FINGER_STATS_EN); all stat_* 0 without macro.
//  rst_n low mid-stream with 2 words in flight -> next cycle out_valid=0, in_ready=0; after release first
//   new word's pixels emerge with x=0.

Source files
------------

// File: rtl/yuv422_rgb_pipe_pkg.sv
// Shared constants, types and helpers for the YUV422->RGB camera-path converter.
// Coefficients are the fixed-point (x256) BT.601 studio-swing factors.
package yuv_rgb_pkg;

  localparam logic signed [31:0] K_Y    = 32'sd298;
  localparam logic signed [31:0] K_RV   = 32'sd409;
  localparam logic signed [31:0] K_GU   = 32'sd100;
  localparam logic signed [31:0] K_GV   = 32'sd208;
  localparam logic signed [31:0] K_BU   = 32'sd516;
  localparam logic signed [31:0] OFF_Y  = 32'sd16;
  localparam logic signed [31:0] OFF_C  = 32'sd128;
  localparam logic signed [31:0] ROUND  = 32'sd128;

  typedef enum logic [1:0] {
    SER_EMPTY,
    SER_PIX1,
    SER_PIX0
  } ser_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  function automatic logic [7:0] clamp8(input logic signed [31:0] v);
    if (v < 0)
      return '0;
    else if (v >= 32'sd65536)
      return '1;
    else
      return v[15:8];
  endfunction

  function automatic logic is_finger(input rgb8_t p, input logic [7:0] r_max,
                                     input logic [7:0] g_min, input logic [7:0] b_max);
    return (p.r < r_max) && (p.g > g_min) && (p.b < b_max);
  endfunction

endpackage

// File: rtl/yuv422_rgb_pipe_if.sv
// Input word stream and output pixel stream of yuv422_rgb_pipe, valid/ready on both sides.
interface yuv422_rgb_pipe_if #(
  parameter int unsigned CH_BITS = 3
);
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_data;
  logic                   in_sol;
  logic                   out_valid;
  logic                   out_ready;
  logic [3*CH_BITS-1:0]   out_rgb;
  logic                   out_finger;
  logic                   out_eol;

  modport slave (
    input  in_valid, in_data, in_sol, out_ready,
    output in_ready, out_valid, out_rgb, out_finger, out_eol
  );

  modport master (
    output in_valid, in_data, in_sol, out_ready,
    input  in_ready, out_valid, out_rgb, out_finger, out_eol
  );
endinterface

// File: rtl/yuv422_rgb_pipe_core.sv
// One-pixel YUV->RGB arithmetic: S1 registers the products, S2 registers the
// clamped 8-bit channels and the finger-colour flag. All state advances only on en.
module yuv_rgb_core
  import yuv_rgb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  y,
  input  logic [7:0]  u,
  input  logic [7:0]  v,
  input  logic [7:0]  thr_r_max,
  input  logic [7:0]  thr_g_min,
  input  logic [7:0]  thr_b_max,
  output rgb8_t       rgb,
  output logic        finger
);

  logic signed [31:0] yd, ud, vd;
  logic signed [31:0] c1, rv1, gu1, gv1, bu1;
  logic signed [31:0] r_sum, g_sum, b_sum;
  rgb8_t              pix_c;

  assign yd = $signed({24'd0, y}) - OFF_Y;
  assign ud = $signed({24'd0, u}) - OFF_C;
  assign vd = $signed({24'd0, v}) - OFF_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1  <= '0;
      rv1 <= '0;
      gu1 <= '0;
      gv1 <= '0;
      bu1 <= '0;
    end else if (en) begin
      c1  <= K_Y  * yd;
      rv1 <= K_RV * vd;
      gu1 <= K_GU * ud;
      gv1 <= K_GV * vd;
      bu1 <= K_BU * ud;
    end
  end

  always_comb begin
    r_sum   = c1 + rv1 + ROUND;
    g_sum   = c1 - gu1 - gv1 + ROUND;
    b_sum   = c1 + bu1 + ROUND;
    pix_c.r = clamp8(r_sum);
    pix_c.g = clamp8(g_sum);
    pix_c.b = clamp8(b_sum);
  end

  // Thresholds are taken live here so a change only affects pixels not yet in S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb    <= '0;
      finger <= 1'b0;
    end else if (en) begin
      rgb    <= pix_c;
      finger <= is_finger(pix_c, thr_r_max, thr_g_min, thr_b_max);
    end
  end

endmodule

// File: rtl/yuv422_rgb_pipe.sv
// Pipelined YUV422->RGB converter: word serializer, two arithmetic stages, output
// register, line x counter and optional per-line finger statistics (FINGER_STATS_EN).
module yuv422_rgb_pipe
  import yuv_rgb_pkg::*;
#(
  parameter int unsigned CH_BITS     = 3,
  parameter int unsigned LINE_PIXELS = 640,
  localparam int unsigned XW         = $clog2(LINE_PIXELS)
)(
  input  logic             clk,
  input  logic             rst_n,
  yuv422_rgb_pipe_if.slave bus,
  input  logic [7:0]       thr_r_max,
  input  logic [7:0]       thr_g_min,
  input  logic [7:0]       thr_b_max,
  output logic             stat_valid,
  output logic [XW:0]      stat_count,
  output logic [XW-1:0]    stat_first,
  output logic [XW-1:0]    stat_last
);

  localparam logic [XW-1:0] X_LAST = XW'(LINE_PIXELS - 1);

  ser_state_t    state, state_nxt;
  logic          run;
  logic          stall, en, accept;
  logic [7:0]    w_y1, w_y0, w_u, w_v;
  logic          w_sol;
  logic          ser_v, ser_sol;
  logic [7:0]    ser_y;
  logic          s1_v, s1_sol, s2_v, s2_sol;
  rgb8_t         s2_rgb;
  logic          s2_finger;
  logic          out_v;
  logic [XW-1:0] x_nxt, x_cur;

  assign stall         = out_v && !bus.out_ready;
  assign en            = !stall;
  assign bus.in_ready  = run && en && (state != SER_PIX1);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_v;

  // Keeps in_ready low while reset is held and for the cycle it releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      run <= 1'b0;
    else
      run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= SER_EMPTY;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SER_EMPTY: if (accept) state_nxt = SER_PIX1;
      SER_PIX1:  if (en)     state_nxt = SER_PIX0;
      SER_PIX0:  if (en)     state_nxt = accept ? SER_PIX1 : SER_EMPTY;
      default:               state_nxt = SER_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {w_v, w_y1, w_u, w_y0} <= '0;
      w_sol                  <= 1'b0;
    end else if (accept) begin
      {w_v, w_y1, w_u, w_y0} <= bus.in_data;
      w_sol                  <= bus.in_sol;
    end
  end

  always_comb begin
    ser_v   = (state != SER_EMPTY);
    ser_y   = (state == SER_PIX1) ? w_y1 : w_y0;
    ser_sol = (state == SER_PIX1) && w_sol;
  end

  yuv_rgb_core u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .y         (ser_y),
    .u         (w_u),
    .v         (w_v),
    .thr_r_max (thr_r_max),
    .thr_g_min (thr_g_min),
    .thr_b_max (thr_b_max),
    .rgb       (s2_rgb),
    .finger    (s2_finger)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_sol <= 1'b0;
      s2_v   <= 1'b0;
      s2_sol <= 1'b0;
    end else if (en) begin
      s1_v   <= ser_v;
      s1_sol <= ser_sol;
      s2_v   <= s1_v;
      s2_sol <= s1_sol;
    end
  end

  // x is bound when a pixel enters the output register; that register only reloads
  // once its previous pixel has been handed off, so this matches per-handshake counting.
  assign x_cur = s2_sol ? '0 : x_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v          <= 1'b0;
      bus.out_rgb    <= '0;
      bus.out_finger <= 1'b0;
      bus.out_eol    <= 1'b0;
      x_nxt          <= '0;
    end else if (en) begin
      out_v <= s2_v;
      if (s2_v) begin
        bus.out_rgb    <= {s2_rgb.r[7 -: CH_BITS], s2_rgb.g[7 -: CH_BITS], s2_rgb.b[7 -: CH_BITS]};
        bus.out_finger <= s2_finger;
        bus.out_eol    <= (x_cur == X_LAST);
        x_nxt          <= (x_cur == X_LAST) ? '0 : x_cur + XW'(1);
      end
    end
  end

`ifdef FINGER_STATS_EN
  logic          out_sol;
  logic [XW-1:0] out_x;
  logic          out_hs;
  logic [XW:0]   acc_count, base_count, new_count;
  logic [XW-1:0] acc_first, acc_last, base_first, base_last, new_first, new_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sol <= 1'b0;
      out_x   <= '0;
    end else if (en && s2_v) begin
      out_sol <= s2_sol;
      out_x   <= x_cur;
    end
  end

  assign out_hs = out_v && bus.out_ready;

  // A pixel carrying sol starts accumulation afresh, dropping the interrupted line.
  always_comb begin
    base_count = out_sol ? '0 : acc_count;
    base_first = out_sol ? '0 : acc_first;
    base_last  = out_sol ? '0 : acc_last;
    new_count  = base_count;
    new_first  = base_first;
    new_last   = base_last;
    if (bus.out_finger) begin
      if (base_count == '0)
        new_first = out_x;
      new_last  = out_x;
      new_count = base_count + {{XW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_count  <= '0;
      acc_first  <= '0;
      acc_last   <= '0;
      stat_valid <= 1'b0;
      stat_count <= '0;
      stat_first <= '0;
      stat_last  <= '0;
    end else begin
      stat_valid <= 1'b0;
      if (out_hs) begin
        if (bus.out_eol) begin
          stat_valid <= 1'b1;
          stat_count <= new_count;
          stat_first <= new_first;
          stat_last  <= new_last;
          acc_count  <= '0;
          acc_first  <= '0;
          acc_last   <= '0;
        end else begin
          acc_count  <= new_count;
          acc_first  <= new_first;
          acc_last   <= new_last;
        end
      end
    end
  end
`else
  assign stat_valid = 1'b0;
  assign stat_count = '0;
  assign stat_first = '0;
  assign stat_last  = '0;
`endif

endmodule

// File: tb/tb_yuv422_rgb_pipe.sv
// Randomised bench for yuv422_rgb_pipe against a plain-arithmetic pixel/line model,
// plus literal colour, latency, stats and reset expectations (honours FINGER_STATS_EN).
module tb_yuv422_rgb_pipe;

  localparam int unsigned CH = 3;
  localparam int unsigned LP = 16;
  localparam int unsigned XW = $clog2(LP);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    thr_r = 8'd200, thr_g = 8'd50, thr_b = 8'd200;
  logic          stat_valid;
  logic [XW:0]   stat_count;
  logic [XW-1:0] stat_first, stat_last;

  always #5 clk = ~clk;

  yuv422_rgb_pipe_if #(.CH_BITS(CH)) bus ();

  yuv422_rgb_pipe #(.CH_BITS(CH), .LINE_PIXELS(LP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .thr_r_max  (thr_r),
    .thr_g_min  (thr_g),
    .thr_b_max  (thr_b),
    .stat_valid (stat_valid),
    .stat_count (stat_count),
    .stat_first (stat_first),
    .stat_last  (stat_last)
  );

  typedef struct {
    int unsigned rgb;
    bit          finger;
    bit          sol;
  } exp_t;

  exp_t exp_q[$];
  int   got_rgb[$], got_x[$], got_cyc[$];
  int   n_checks = 0, n_pass = 0;
  int   cyc = 0, acc_cyc = 0, rdy_pct = 100;
  int   m_x = LP - 1;
  bit   line_f[LP];
  bit   pend = 1'b0;
  int   pc = 0, pf = 0, pl = 0;
  int   pulses = 0, last_cnt = 0, last_first = 0, last_last = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
  endtask

  function automatic int clampm(input int v);
    if (v < 0) return 0;
    if (v > 65535) return 255;
    return v / 256;
  endfunction

  function automatic exp_t model(input int y, input int u, input int v, input bit s);
    exp_t e;
    int c, r, g, b;
    c = 298 * (y - 16);
    r = clampm(c + 409 * (v - 128) + 128);
    g = clampm(c - 100 * (u - 128) - 208 * (v - 128) + 128);
    b = clampm(c + 516 * (u - 128) + 128);
    e.rgb    = ((r >> (8 - CH)) << (2 * CH)) | ((g >> (8 - CH)) << CH) | (b >> (8 - CH));
    e.finger = (r < int'(thr_r)) && (g > int'(thr_g)) && (b < int'(thr_b));
    e.sol    = s;
    return e;
  endfunction

  task automatic push_word(input logic [31:0] d, input bit s);
    exp_q.push_back(model(int'(d[23:16]), int'(d[15:8]), int'(d[31:24]), s));
    exp_q.push_back(model(int'(d[7:0]),   int'(d[15:8]), int'(d[31:24]), 1'b0));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.out_ready = ($urandom_range(99) < rdy_pct);
  end

  always @(negedge clk) begin
    if (rst_n) begin
`ifdef FINGER_STATS_EN
      check("stat_valid", int'(stat_valid), int'(pend));
      if (stat_valid) begin
        pulses++;
        last_cnt   = int'(stat_count);
        last_first = int'(stat_first);
        last_last  = int'(stat_last);
      end
      if (pend) begin
        check("stat_count", int'(stat_count), pc);
        check("stat_first", int'(stat_first), pf);
        check("stat_last",  int'(stat_last),  pl);
      end
`else
      check("stat_tied0", int'({stat_valid, stat_count, stat_first, stat_last}), 0);
`endif
      pend = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          exp_t e;
          e   = exp_q.pop_front();
          m_x = e.sol ? 0 : ((m_x == LP - 1) ? 0 : m_x + 1);
          check("pixel{rgb,finger,eol}", int'({bus.out_rgb, bus.out_finger, bus.out_eol}),
                int'(e.rgb * 4 + e.finger * 2 + ((m_x == LP - 1) ? 1 : 0)));
          got_rgb.push_back(int'(bus.out_rgb));
          got_x.push_back(m_x);
          got_cyc.push_back(cyc);
          if (e.sol) foreach (line_f[i]) line_f[i] = 1'b0;
          line_f[m_x] = e.finger;
          if (m_x == LP - 1) begin
            pc = 0; pf = 0; pl = 0;
            for (int i = 0; i < int'(LP); i++) begin
              if (line_f[i]) begin
                if (pc == 0) pf = i;
                pl = i;
                pc++;
              end
            end
            pend = 1'b1;
            foreach (line_f[i]) line_f[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit s);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sol   = s;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = bus.in_ready;
      if (hs) begin
        push_word(d, s);
        acc_cyc = cyc + 1;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!hs) check("in_handshake_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_x  = LP - 1;
    pend = 1'b0;
    foreach (line_f[i]) line_f[i] = 1'b0;
  endtask

  initial begin
    int base;
    logic [31:0] w;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sol   = 1'b0;

    #12;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_in_ready",  int'(bus.in_ready), 0);
    check("reset_out_rgb",   int'(bus.out_rgb), 0);
    check("reset_stats", int'({stat_valid, stat_count, stat_first, stat_last}), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Black with sol, latency +3/+4 at full rate
    base = got_rgb.size();
    send({8'd128, 8'd16, 8'd128, 8'd16}, 1'b1);
    drain();
    check("black_y1_rgb", got_rgb[base], 9'h000);
    check("black_y0_rgb", got_rgb[base + 1], 9'h000);
    check("black_y1_latency", got_cyc[base] - acc_cyc, 3);
    check("black_y0_latency", got_cyc[base + 1] - acc_cyc, 4);
    check("black_y1_x", got_x[base], 0);

    base = got_rgb.size();
    send({8'd128, 8'd235, 8'd128, 8'd235}, 1'b0);
    send({8'd240, 8'd81, 8'd90, 8'd81}, 1'b0);
    drain();
    check("white_y1_rgb", got_rgb[base], 9'h1FF);
    check("white_y0_rgb", got_rgb[base + 1], 9'h1FF);
    check("red_y1_rgb",   got_rgb[base + 2], 9'h1C0);
    check("red_y0_rgb",   got_rgb[base + 3], 9'h1C0);

    // Back-pressure: 8 words, 50% out_ready
    rdy_pct = 50;
    base = got_rgb.size();
    for (int k = 0; k < 8; k++) send($urandom, 1'b0);
    drain();
    check("backpressure_pixel_count", got_rgb.size() - base, 16);

    // Random stream with occasional mid-line sol
    rdy_pct = 70;
    for (int k = 0; k < 80; k++) begin
      w = $urandom;
      if (($urandom_range(3)) == 0) w = {8'd128, 8'd102, 8'd128, w[7:0]};
      send(w, ($urandom_range(7) == 0));
    end
    drain();

    // Finger line: gray (100,100,100) at x=5..9, rest white
    rdy_pct = 60;
    pulses  = 0;
    base    = got_rgb.size();
    for (int k = 0; k < int'(LP / 2); k++) begin
      logic [7:0] y1, y0;
      y1 = ((2 * k) >= 5 && (2 * k) <= 9) ? 8'd102 : 8'd235;
      y0 = ((2 * k + 1) >= 5 && (2 * k + 1) <= 9) ? 8'd102 : 8'd235;
      send({8'd128, y1, 8'd128, y0}, (k == 0));
    end
    drain();
    check("finger_line_last_x", got_x[base + LP - 1], LP - 1);
`ifdef FINGER_STATS_EN
    check("finger_pulses", pulses, 1);
    check("finger_count", last_cnt, 5);
    check("finger_first", last_first, 5);
    check("finger_last",  last_last, 9);
`else
    check("finger_stats_absent", int'({stat_valid, stat_count, stat_first, stat_last}), 0);
`endif

    // Reset with two words in flight
    rdy_pct = 0;
    repeat (2) @(posedge clk);
    #1;
    send($urandom, 1'b0);
    send($urandom, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset_out_valid", int'(bus.out_valid), 0);
    check("midreset_in_ready",  int'(bus.in_ready), 0);
    @(negedge clk);
    check("midreset_next_out_valid", int'(bus.out_valid), 0);
    check("midreset_next_in_ready",  int'(bus.in_ready), 0);
    check("midreset_stat_valid",     int'(stat_valid), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    rdy_pct = 100;
    @(posedge clk); #1;
    base = got_rgb.size();
    send($urandom, 1'b0);
    drain();
    check("post_reset_pixels", got_rgb.size() - base, 2);
    check("post_reset_x0", got_x[base], 0);
    check("post_reset_x1", got_x[base + 1], 1);
    check("leftover_expected", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

endmodule
